// File: rtl/game_pkg.sv
// Shared game definitions: score FSM states, lane numbering and the coin hit window
// used by both the spawn units and the score keeper.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      ADD  = 2'd2
   } score_state_t;

   localparam int LANE_LEFT  = 0;
   localparam int LANE_MID   = 1;
   localparam int LANE_RIGHT = 2;

   localparam int HIT_LO_DEF = 150;
   localparam int HIT_HI_DEF = 220;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with synchronous clear and an increment that
// saturates at all nines.
module bcd_counter #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
   output logic [4*DIGITS-1:0] q,
   output logic                max
);

   logic [4*DIGITS-1:0] nxt;
   logic                carry;

   always_comb begin
      max   = (q == {DIGITS{4'h9}});
      nxt   = q;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (q[4*d +: 4] == 4'h9) begin
               nxt[4*d +: 4] = 4'h0;
            end else begin
               nxt[4*d +: 4] = q[4*d +: 4] + 4'h1;
               carry         = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && !max) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Per-frame coin collision scan and BCD score/high-score keeper; one lane is
// examined per cycle, then credited coins are added one per cycle.
module score_keeper
   import game_pkg::*;
#(
   parameter int LANES  = 3,
   parameter int VWIDTH = 12,
   parameter int HIT_LO = HIT_LO_DEF,
   parameter int HIT_HI = HIT_HI_DEF,
   parameter int DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_tick,
   input  logic                    play,
   input  logic [1:0]              player_lane,
   input  logic [LANES-1:0]        coin_active,
   input  logic [LANES*VWIDTH-1:0] coin_voffset,
   output logic [LANES-1:0]        coin_hide,
   output logic                    hit,
   output logic [4*DIGITS-1:0]     score_bcd,
   output logic [4*DIGITS-1:0]     high_bcd,
   output logic                    busy
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW = $clog2(LANES + 1);

   score_state_t              state;
   logic [IW-1:0]             idx;
   logic [PW-1:0]             pending;
   logic [PW-1:0]             pend_scan;
   logic [LANES-1:0]          collected;
   logic                      tick_pend;
   logic                      play_q;
   logic                      hi_pend;
   logic signed [VWIDTH-1:0]  voff;
   logic                      lane_hit;
   logic                      last_lane;
   logic                      restart;
   logic                      play_rise;
   logic                      play_fall;
   logic                      score_gt;
   logic                      score_max;
   logic                      decided;

   always_comb begin
      voff      = coin_voffset[idx*VWIDTH +: VWIDTH];
      lane_hit  = (state == SCAN) && coin_active[idx] && !collected[idx] &&
                  (int'(player_lane) == int'(idx)) &&
                  (int'(voff) >= HIT_LO) && (int'(voff) <= HIT_HI);
      last_lane = (int'(idx) == LANES - 1);
      pend_scan = pending + PW'(lane_hit);
      restart   = (frame_tick || tick_pend) && play;
      play_rise = play && !play_q;
      play_fall = !play && play_q;
   end

   // BCD magnitude compare, most significant digit decides first
   always_comb begin
      score_gt = 1'b0;
      decided  = 1'b0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         if (!decided && (score_bcd[4*d +: 4] != high_bcd[4*d +: 4])) begin
            score_gt = (score_bcd[4*d +: 4] > high_bcd[4*d +: 4]);
            decided  = 1'b1;
         end
      end
   end

   bcd_counter #(.DIGITS(DIGITS)) u_score (
      .clk (clk),
      .rst (rst),
      .clr (play_rise),
      .inc ((state == ADD) && !score_max),
      .q   (score_bcd),
      .max (score_max)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         pending   <= '0;
         collected <= '0;
         coin_hide <= '0;
         tick_pend <= 1'b0;
         hit       <= 1'b0;
         busy      <= 1'b0;
         play_q    <= 1'b0;
         hi_pend   <= 1'b0;
         high_bcd  <= '0;
      end else begin
         hit    <= 1'b0;
         play_q <= play;
         for (int i = 0; i < LANES; i++) begin
            if (!coin_active[i]) begin
               collected[i] <= 1'b0;
               coin_hide[i] <= 1'b0;
            end
         end

         // A game that ends mid-frame is recorded once the frame has settled
         if ((state == IDLE) && (play_fall || hi_pend)) begin
            if (score_gt) high_bcd <= score_bcd;
            hi_pend <= 1'b0;
         end else if (play_fall) begin
            hi_pend <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (frame_tick || tick_pend) begin
                  tick_pend <= 1'b0;
                  if (play) begin
                     state <= SCAN;
                     idx   <= '0;
                     busy  <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (frame_tick) tick_pend <= 1'b1;
               if (lane_hit) begin
                  collected[idx] <= 1'b1;
                  coin_hide[idx] <= 1'b1;
               end
               pending <= pend_scan;
               if (!last_lane) begin
                  idx <= idx + 1'b1;
               end else if (pend_scan != '0) begin
                  state <= ADD;
               end else begin
                  // A tick latched during the frame restarts without leaving busy
                  state     <= restart ? SCAN : IDLE;
                  busy      <= restart;
                  idx       <= '0;
                  tick_pend <= 1'b0;
               end
            end
            ADD: begin
               if (frame_tick) tick_pend <= 1'b1;
               hit     <= 1'b1;
               pending <= pending - 1'b1;
               if (pending == PW'(1)) begin
                  state     <= restart ? SCAN : IDLE;
                  busy      <= restart;
                  idx       <= '0;
                  tick_pend <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: predicted scores are queued as coins are
// presented and popped as hit pulses appear.
module tb_score_keeper;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        play;
   logic [1:0]  player_lane;
   logic [2:0]  coin_active;
   logic [35:0] coin_voffset;
   logic [2:0]  coin_hide;
   logic        hit;
   logic [15:0] score_bcd;
   logic [15:0] high_bcd;
   logic        busy;

   int          voff[3];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          hit_count = 0;
   int          model_score = 0;
   logic [2:0]  mcoll = '0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   always_comb begin
      coin_voffset = '0;
      for (int i = 0; i < 3; i++) coin_voffset[i*12 +: 12] = 12'(voff[i]);
   end

   score_keeper dut (
      .clk          (clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .play         (play),
      .player_lane  (player_lane),
      .coin_active  (coin_active),
      .coin_voffset (coin_voffset),
      .coin_hide    (coin_hide),
      .hit          (hit),
      .score_bcd    (score_bcd),
      .high_bcd     (high_bcd),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic push_hit();
      model_score = (model_score < 9999) ? model_score + 1 : 9999;
      exp_q.push_back(to_bcd(model_score));
   endtask

   // Every hit pulse must match the next queued score
   initial begin
      forever begin
         @(negedge clk);
         if (hit === 1'b1) begin
            hit_count++;
            if (exp_q.size() == 0) check("hit_extra", 32'(hit), 32'd0);
            else check("hit_score", 32'(score_bcd), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check("idle_wait", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic set_coin(input int lane, input bit act, input int v);
      @(negedge clk);
      coin_active[lane] = act;
      voff[lane] = v;
      if (!act) mcoll[lane] = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic respawn(input int v);
      set_coin(1, 1'b0, v);
      set_coin(1, 1'b1, v);
   endtask

   task automatic frame();
      for (int i = 0; i < 3; i++) begin
         if (coin_active[i] && (int'(player_lane) == i) && voff[i] >= 150 &&
             voff[i] <= 220 && !mcoll[i]) begin
            mcoll[i] = 1'b1;
            push_hit();
         end
      end
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      wait_idle();
      check("coin_hide", 32'(coin_hide), 32'(mcoll));
      check("score", 32'(score_bcd), 32'(to_bcd(model_score)));
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   // One credited coin every four cycles, ticks chained through the pending latch
   task automatic fast_hits(input int n);
      @(negedge clk);
      coin_active = '0;
      player_lane = 2'd1;
      voff[1] = 200;
      mcoll = '0;
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < n; j++) begin
         push_hit();
         frame_tick = 1'b1;
         coin_active = 3'b010;
         @(negedge clk) frame_tick = 1'b0;
         @(negedge clk);
         @(negedge clk) coin_active = '0;
         @(negedge clk);
      end
      wait_idle();
      check("run_score", 32'(score_bcd), 32'(to_bcd(model_score)));
      check("run_queue", exp_q.size(), 32'd0);
   endtask

   initial begin
      int hc;
      int run;
      int gaps;
      bit seen_low;
      int bad_v[3];
      bad_v[0] = -140; bad_v[1] = 149; bad_v[2] = 221;

      rst = 1'b1; frame_tick = 1'b0; play = 1'b0; player_lane = 2'd0;
      coin_active = '0;
      for (int i = 0; i < 3; i++) voff[i] = 0;
      repeat (3) @(negedge clk);
      check("rst_hide", 32'(coin_hide), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_score", 32'(score_bcd), 32'd0);
      check("rst_high", 32'(high_bcd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      play = 1'b1;
      player_lane = 2'd1;

      set_coin(1, 1'b1, 200);
      frame();
      check("first_hide", 32'(coin_hide), 32'h2);
      check("first_score", 32'(score_bcd), 32'h0001);
      set_coin(1, 1'b1, 210);
      frame();
      respawn(180);
      frame();
      check("respawn_score", 32'(score_bcd), 32'h0002);
      set_coin(0, 1'b1, 200);
      for (int k = 0; k < 3; k++) begin
         respawn(bad_v[k]);
         frame();
      end
      respawn(150);
      frame();
      respawn(220);
      frame();
      check("edges_score", 32'(score_bcd), 32'h0004);

      fast_hits(38);
      check("score_42", 32'(score_bcd), 32'h0042);
      @(negedge clk) play = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("high_42", 32'(high_bcd), 32'h0042);
      play = 1'b1;
      model_score = 0;
      @(negedge clk);
      @(negedge clk);
      check("score_clr", 32'(score_bcd), 32'd0);
      fast_hits(7);
      @(negedge clk) play = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("high_kept", 32'(high_bcd), 32'h0042);
      play = 1'b1;
      model_score = 0;
      @(negedge clk);
      @(negedge clk);

      fast_hits(9998);
      check("score_9998", 32'(score_bcd), 32'h9998);
      hc = hit_count;
      respawn(200);
      frame();
      respawn(200);
      frame();
      check("sat_score", 32'(score_bcd), 32'h9999);
      check("sat_hits", hit_count - hc, 32'd2);

      respawn(200);
      player_lane = 2'd3;
      @(negedge clk) frame_tick = 1'b1;
      run = 0; gaps = 0; seen_low = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         frame_tick = (k < 2);
         if (busy) begin
            run++;
            if (seen_low) gaps++;
         end else if (run > 0) begin
            seen_low = 1'b1;
         end
      end
      check("busy_run", run, 32'd6);
      check("busy_gap", gaps, 32'd0);
      check("lane3_score", 32'(score_bcd), 32'h9999);

      player_lane = 2'd1;
      respawn(200);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("busy_in_add", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("arst_hide", 32'(coin_hide), 32'd0);
      check("arst_hit", 32'(hit), 32'd0);
      check("arst_score", 32'(score_bcd), 32'd0);
      check("arst_high", 32'(high_bcd), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      model_score = 0;
      mcoll = '0;
      repeat (4) @(negedge clk);
      check("final_queue", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
